// File: rtl/sd_xfer_sched.sv
// SD host transfer scheduler: runs one descriptor through CMD, then DAT + ADMA, and reports the outcome.
// Optional feature macro AUTO_CMD12_EN: automatic CMD12 after multi-block transfers and on abort.
module sd_xfer_sched #(
  parameter int CMD_TIMEOUT = 64,
  parameter int TO_W        = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        data_present,
  input  logic [15:0] block_count,
  input  logic        stop,
  output logic        cmd_req,
  input  logic        cmd_ack,
  output logic [5:0]  cmd_idx_o,
  output logic [31:0] cmd_arg_o,
  input  logic        cmd_done,
  input  logic        cmd_error,
  output logic        dat_start,
  input  logic        dat_block_done,
  input  logic        dat_error,
  output logic        dma_start,
  input  logic        dma_done,
  output logic        busy,
  output logic [15:0] blocks_left,
  output logic        xfer_done,
  output logic        error,
  output logic [2:0]  err_code
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CMD_ISSUE = 4'd1;
  localparam logic [3:0] ST_CMD_WAIT  = 4'd2;
  localparam logic [3:0] ST_DAT_RUN   = 4'd3;
  localparam logic [3:0] ST_DMA_DRAIN = 4'd4;
  localparam logic [3:0] ST_DONE      = 4'd5;
  localparam logic [3:0] ST_ERR       = 4'd6;
`ifdef AUTO_CMD12_EN
  localparam logic [3:0] ST_AUTO_ISSUE = 4'd7;
  localparam logic [3:0] ST_AUTO_WAIT  = 4'd8;
  localparam logic [5:0] CMD12_IDX     = 6'd12;
`endif

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD     = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_DAT     = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;
  localparam logic [2:0] ERR_COUNT   = 3'd5;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CMD_TIMEOUT - 1);

  logic [3:0]      state_r;
  logic [3:0]      state_nx_s;
  logic [2:0]      code_nx_s;
  logic            accept_s;
  logic            dec_s;
  logic            in_wait_s;
  logic [TO_W-1:0] to_cnt_r;
  logic            cmd_req_r;
  logic [5:0]      cmd_idx_r;
  logic [31:0]     cmd_arg_r;
  logic            dp_r;
  logic            dat_start_r;
  logic            dma_start_r;
  logic            dma_seen_r;
  logic            busy_r;
  logic [15:0]     blocks_left_r;
  logic            xfer_done_r;
  logic            error_r;
  logic [2:0]      err_code_r;
`ifdef AUTO_CMD12_EN
  logic            multi_r;
  logic            auto_stop_r;
  logic            auto_stop_nx_s;
`endif

  // Next-state and error-code selection; all exits honour the documented priorities.
  always_comb begin
    state_nx_s = state_r;
    code_nx_s  = err_code_r;
    accept_s   = 1'b0;
    dec_s      = 1'b0;
`ifdef AUTO_CMD12_EN
    auto_stop_nx_s = auto_stop_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
`ifdef AUTO_CMD12_EN
          auto_stop_nx_s = 1'b0;
`endif
          if (data_present && (block_count == 16'd0)) begin
            state_nx_s = ST_ERR;
            code_nx_s  = ERR_COUNT;
          end else begin
            state_nx_s = ST_CMD_ISSUE;
            code_nx_s  = ERR_NONE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CMD_ISSUE: begin
        if (cmd_req_r && cmd_ack) begin
          state_nx_s = ST_CMD_WAIT;
        end else begin
          state_nx_s = ST_CMD_ISSUE;
        end
      end
      ST_CMD_WAIT: begin
        if (cmd_error) begin
          state_nx_s = ST_ERR;
          code_nx_s  = ERR_CMD;
        end else if (cmd_done) begin
          if (dp_r) begin
            state_nx_s = ST_DAT_RUN;
          end else begin
            state_nx_s = ST_DONE;
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_nx_s = ST_ERR;
          code_nx_s  = ERR_TIMEOUT;
        end else begin
          state_nx_s = ST_CMD_WAIT;
        end
      end
      ST_DAT_RUN: begin
        if (dat_error) begin
          state_nx_s = ST_ERR;
          code_nx_s  = ERR_DAT;
        end else if (stop) begin
`ifdef AUTO_CMD12_EN
          state_nx_s     = ST_AUTO_ISSUE;
          auto_stop_nx_s = 1'b1;
`else
          state_nx_s = ST_ERR;
          code_nx_s  = ERR_ABORT;
`endif
        end else if (dat_block_done) begin
          dec_s = 1'b1;
          if (blocks_left_r == 16'd1) begin
            state_nx_s = ST_DMA_DRAIN;
          end else begin
            state_nx_s = ST_DAT_RUN;
          end
        end else begin
          state_nx_s = ST_DAT_RUN;
        end
      end
      ST_DMA_DRAIN: begin
        if (dma_seen_r || dma_done) begin
`ifdef AUTO_CMD12_EN
          if (multi_r) begin
            state_nx_s = ST_AUTO_ISSUE;
          end else begin
            state_nx_s = ST_DONE;
          end
`else
          state_nx_s = ST_DONE;
`endif
        end else if (stop) begin
`ifdef AUTO_CMD12_EN
          state_nx_s     = ST_AUTO_ISSUE;
          auto_stop_nx_s = 1'b1;
`else
          state_nx_s = ST_ERR;
          code_nx_s  = ERR_ABORT;
`endif
        end else begin
          state_nx_s = ST_DMA_DRAIN;
        end
      end
`ifdef AUTO_CMD12_EN
      ST_AUTO_ISSUE: begin
        if (cmd_req_r && cmd_ack) begin
          state_nx_s = ST_AUTO_WAIT;
        end else begin
          state_nx_s = ST_AUTO_ISSUE;
        end
      end
      ST_AUTO_WAIT: begin
        if (cmd_error) begin
          state_nx_s = ST_ERR;
          code_nx_s  = ERR_CMD;
        end else if (cmd_done) begin
          if (auto_stop_r) begin
            state_nx_s = ST_ERR;
            code_nx_s  = ERR_ABORT;
          end else begin
            state_nx_s = ST_DONE;
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_nx_s = ST_ERR;
          code_nx_s  = ERR_TIMEOUT;
        end else begin
          state_nx_s = ST_AUTO_WAIT;
        end
      end
`endif
      ST_DONE: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Timeout counting is shared by the normal and automatic command waits.
  always_comb begin
`ifdef AUTO_CMD12_EN
    in_wait_s = (state_r == ST_CMD_WAIT) || (state_r == ST_AUTO_WAIT);
`else
    in_wait_s = (state_r == ST_CMD_WAIT);
`endif
  end

  // State, latched descriptor fields and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r       <= ST_IDLE;
      to_cnt_r      <= '0;
      cmd_req_r     <= 1'b0;
      cmd_idx_r     <= 6'd0;
      cmd_arg_r     <= 32'd0;
      dp_r          <= 1'b0;
      dat_start_r   <= 1'b0;
      dma_start_r   <= 1'b0;
      dma_seen_r    <= 1'b0;
      busy_r        <= 1'b0;
      blocks_left_r <= 16'd0;
      xfer_done_r   <= 1'b0;
      error_r       <= 1'b0;
      err_code_r    <= ERR_NONE;
`ifdef AUTO_CMD12_EN
      multi_r       <= 1'b0;
      auto_stop_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_nx_s;
      err_code_r  <= code_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
      xfer_done_r <= (state_nx_s == ST_DONE);
      error_r     <= (state_nx_s == ST_ERR);
      dat_start_r <= (state_nx_s == ST_DAT_RUN) && (state_r != ST_DAT_RUN);
      dma_start_r <= (state_nx_s == ST_DAT_RUN) && (state_r != ST_DAT_RUN);
`ifdef AUTO_CMD12_EN
      cmd_req_r   <= (state_nx_s == ST_CMD_ISSUE) || (state_nx_s == ST_AUTO_ISSUE);
      auto_stop_r <= auto_stop_nx_s;
`else
      cmd_req_r   <= (state_nx_s == ST_CMD_ISSUE);
`endif
      to_cnt_r <= in_wait_s ? (to_cnt_r + TO_W'(1)) : '0;

      if (accept_s) begin
        cmd_idx_r     <= cmd_index;
        cmd_arg_r     <= cmd_arg;
        dp_r          <= data_present;
        blocks_left_r <= block_count;
`ifdef AUTO_CMD12_EN
        multi_r       <= (block_count > 16'd1);
      end else if ((state_nx_s == ST_AUTO_ISSUE) && (state_r != ST_AUTO_ISSUE)) begin
        cmd_idx_r <= CMD12_IDX;
        cmd_arg_r <= 32'd0;
`endif
      end else if (dec_s && (blocks_left_r != 16'd0)) begin
        blocks_left_r <= blocks_left_r - 16'd1;
      end

      // dma_done may land at any point after dma_start, so it is remembered until the next descriptor.
      if (accept_s) begin
        dma_seen_r <= 1'b0;
      end else if (dma_done) begin
        dma_seen_r <= 1'b1;
      end
    end
  end

  assign cmd_req     = cmd_req_r;
  assign cmd_idx_o   = cmd_idx_r;
  assign cmd_arg_o   = cmd_arg_r;
  assign dat_start   = dat_start_r;
  assign dma_start   = dma_start_r;
  assign busy        = busy_r;
  assign blocks_left = blocks_left_r;
  assign xfer_done   = xfer_done_r;
  assign error       = error_r;
  assign err_code    = err_code_r;

endmodule
